// File: rtl/unpack_scheduler.sv
// unpack_scheduler
//   Shares the 32-bit -> byte unpacker between two valid/ready word sources.
//   Round-robin arbitration picks a word. The word is issued as a one-cycle
//   data_valid pulse. The block then waits for the unpacker's four byte pushes,
//   plus one settle cycle, before it can accept the next word. A new word is
//   accepted only when the byte FIFO reports room for four bytes.
//
// Ports
//   clk_pll, reset_n      : clock (rising edge), asynchronous active-low reset
//   enable                : gates new grants only; a word in flight completes
//   s0_*/s1_*             : word sources (data/valid in, combinational ready out)
//   fifo_free             : byte-FIFO free-slot count (registered upstream)
//   push_mon              : unpacker byte-push strobe
//   data, data_valid      : word and one-cycle issue pulse to the unpacker
//   grant_src             : source of the most recently accepted word
//   busy                  : high in every state except IDLE
//   err_timeout/err_clear : sticky drain-timeout flag and its clear
module unpack_scheduler #(
    parameter int FREE_W  = 6,
    parameter int TIMEOUT = 8
) (
    input  logic              clk_pll,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [31:0]       s0_data,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [31:0]       s1_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [FREE_W-1:0] fifo_free,
    input  logic              push_mon,
    output logic [31:0]       data,
    output logic              data_valid,
    output logic              grant_src,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clear
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rr;
    logic [2:0]  r_push_cnt;
    logic [7:0]  r_timer;
    logic [31:0] r_data;
    logic        r_grant_src;
    logic        r_err;

    logic        w_elig;
    logic        w_gnt1;
    logic        w_xfer;
    logic        w_push_done;
    logic [7:0]  w_timer_nxt;
    logic        w_tmo;

    // Ready is gated with reset_n so neither source sees a transfer while
    // reset is held, even though the state register already reads IDLE.
    assign w_elig   = reset_n && (r_state == S_IDLE) && enable &&
                      (fifo_free >= FREE_W'(4));
    // Source 1 wins when it is the only requester or when it holds the pointer.
    assign w_gnt1   = s1_valid && (!s0_valid || r_rr);
    assign s0_ready = w_elig && s0_valid && !w_gnt1;
    assign s1_ready = w_elig && w_gnt1;
    assign w_xfer   = s0_ready || s1_ready;

    // The 4th push is counted in the same cycle it arrives, so DRAIN exits then.
    assign w_push_done = push_mon && (r_push_cnt == 3'd3);
    assign w_timer_nxt = r_timer + 8'd1;
    assign w_tmo       = !w_push_done && (w_timer_nxt == TMO);

    always_ff @(posedge clk_pll or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_push_done || w_tmo) w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pll or negedge reset_n) begin
        if (!reset_n) begin
            r_rr        <= 1'b0;
            r_data      <= 32'd0;
            r_grant_src <= 1'b0;
            r_push_cnt  <= 3'd0;
            r_timer     <= 8'd0;
        end else begin
            if (w_xfer) begin
                r_data      <= w_gnt1 ? s1_data : s0_data;
                r_grant_src <= w_gnt1;
                r_rr        <= !w_gnt1;
            end
            if (r_state == S_ISSUE) begin
                r_push_cnt <= 3'd0;
                r_timer    <= 8'd0;
            end else if (r_state == S_DRAIN) begin
                r_timer <= w_timer_nxt;
                if (push_mon) r_push_cnt <= r_push_cnt + 3'd1;
            end
        end
    end

    // A timeout set wins over a clear in the same cycle.
    always_ff @(posedge clk_pll or negedge reset_n) begin
        if (!reset_n)                          r_err <= 1'b0;
        else if ((r_state == S_DRAIN) && w_tmo) r_err <= 1'b1;
        else if (err_clear)                    r_err <= 1'b0;
    end

    assign data        = r_data;
    assign data_valid  = (r_state == S_ISSUE);
    assign grant_src   = r_grant_src;
    assign busy        = (r_state != S_IDLE);
    assign err_timeout = r_err;

endmodule

// File: tb/tb_unpack_scheduler.sv
module tb_unpack_scheduler;

    logic        clk_pll = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] s0_data = 32'd0;
    logic        s0_valid = 1'b0;
    logic        s0_ready;
    logic [31:0] s1_data = 32'd0;
    logic        s1_valid = 1'b0;
    logic        s1_ready;
    logic [5:0]  fifo_free = 6'd16;
    logic        push_mon = 1'b0;
    logic [31:0] data;
    logic        data_valid;
    logic        grant_src;
    logic        busy;
    logic        err_timeout;
    logic        err_clear = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_push_allow = 4;

    unpack_scheduler #(.FREE_W(6), .TIMEOUT(8)) dut (
        .clk_pll(clk_pll), .reset_n(reset_n), .enable(enable),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .fifo_free(fifo_free), .push_mon(push_mon),
        .data(data), .data_valid(data_valid), .grant_src(grant_src),
        .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear)
    );

    always #5 clk_pll = ~clk_pll;
    always @(posedge clk_pll) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(negedge clk_pll);
    endtask

    task automatic wait_dv(input string tag, output int at);
        int n = 0;
        while (!data_valid && n < 20) begin tick(); n++; end
        chk({tag, "_seen"}, {31'd0, data_valid}, 32'd1);
        at = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // Unpacker model: pushes two to five cycles after the data_valid cycle,
    // i.e. cycles t+3..t+6 relative to the transfer cycle t.
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk_pll);
            if (!reset_n)         ph = 0;
            else if (data_valid)  ph = 1;
            else if (ph > 0 && ph < 7) ph++;
            else                  ph = 0;
            push_mon = (ph >= 3 && ph <= 6 && (ph - 3) < n_push_allow);
        end
    end

    initial begin
        int t0, t1, bad;
        // Reset state, with a valid held to show ready stays low in reset
        tick(); tick();
        s0_valid = 1'b1;
        #1;
        chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_grant", {31'd0, grant_src}, 32'd0);
        s0_valid = 1'b0;
        tick();
        reset_n = 1'b1;

        // Single word
        tick();
        s0_valid = 1'b1; s0_data = 32'hDDCCBBAA;
        #1;
        chk("sw_s0_ready", {31'd0, s0_ready}, 32'd1);
        chk("sw_s1_ready", {31'd0, s1_ready}, 32'd0);
        tick();
        s0_valid = 1'b0;
        chk("sw_dv", {31'd0, data_valid}, 32'd1);
        chk("sw_data", data, 32'hDDCCBBAA);
        chk("sw_grant", {31'd0, grant_src}, 32'd0);
        bad = 0;
        for (int k = 2; k <= 7; k++) begin
            tick();
            if (!busy || data_valid) bad++;
        end
        chk("sw_busy_t2_t7", bad, 0);
        tick();
        chk("sw_idle_t8", {31'd0, busy}, 32'd0);

        // Round-robin from a fresh reset (pointer back at 0)
        reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
        fifo_free = 6'd32;
        tick();
        s0_valid = 1'b1; s0_data = 32'h11110000;
        s1_valid = 1'b1; s1_data = 32'h22220000;
        t0 = 0;
        for (int i = 0; i < 4; i++) begin
            wait_dv($sformatf("rr%0d", i), t1);
            chk($sformatf("rr%0d_grant", i), {31'd0, grant_src}, (i % 2));
            chk($sformatf("rr%0d_data", i), data, (i % 2) ? 32'h22220000 : 32'h11110000);
            if (i > 0) chk($sformatf("rr%0d_gap", i), t1 - t0, 8);
            t0 = t1;
            if (i == 3) begin s0_valid = 1'b0; s1_valid = 1'b0; end
            tick();
        end
        wait_idle("rr_idle");

        // FIFO backpressure
        fifo_free = 6'd3;
        s1_valid = 1'b1; s1_data = 32'hCAFEF00D;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (s0_ready || s1_ready || data_valid) bad++;
            tick();
        end
        chk("bp_blocked", bad, 0);
        fifo_free = 6'd4;
        #1;
        chk("bp_s1_ready", {31'd0, s1_ready}, 32'd1);
        tick();
        s1_valid = 1'b0; fifo_free = 6'd16;
        chk("bp_dv", {31'd0, data_valid}, 32'd1);
        chk("bp_data", data, 32'hCAFEF00D);
        chk("bp_grant", {31'd0, grant_src}, 32'd1);
        wait_idle("bp_idle");

        // Drain timeout: only two pushes
        n_push_allow = 2;
        tick();
        s0_valid = 1'b1; s0_data = 32'h0BADBEEF;
        #1;
        chk("to_s0_ready", {31'd0, s0_ready}, 32'd1);
        tick();
        s0_valid = 1'b0;
        chk("to_dv", {31'd0, data_valid}, 32'd1);
        for (int k = 0; k < 8; k++) tick();
        chk("to_err_t9", {31'd0, err_timeout}, 32'd0);
        tick();
        chk("to_err_t10", {31'd0, err_timeout}, 32'd1);
        chk("to_settle_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("to_idle_t11", {31'd0, busy}, 32'd0);
        chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("to_err_cleared", {31'd0, err_timeout}, 32'd0);
        n_push_allow = 4;

        // enable dropped during DRAIN
        s0_valid = 1'b1; s0_data = 32'h33333333;
        #1;
        chk("en_s0_ready", {31'd0, s0_ready}, 32'd1);
        tick();
        s0_valid = 1'b0;
        chk("en_dv", {31'd0, data_valid}, 32'd1);
        tick(); tick();
        enable = 1'b0;
        s0_valid = 1'b1; s1_valid = 1'b1; s1_data = 32'h44444444;
        wait_idle("en_word_done");
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (s0_ready || s1_ready || data_valid || busy) bad++;
            tick();
        end
        chk("en_no_grant", bad, 0);
        enable = 1'b1;
        #1;
        chk("en_s1_ready", {31'd0, s1_ready}, 32'd1);
        chk("en_s0_ready_lo", {31'd0, s0_ready}, 32'd0);
        tick();
        chk("en_dv2", {31'd0, data_valid}, 32'd1);
        chk("en_grant", {31'd0, grant_src}, 32'd1);

        // Reset during DRAIN
        tick(); tick();
        chk("rw_busy_pre", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_data", data, 32'd0);
        chk("rw_grant", {31'd0, grant_src}, 32'd0);
        chk("rw_dv", {31'd0, data_valid}, 32'd0);
        chk("rw_s0_ready", {31'd0, s0_ready}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("rw_rr0_s0", {31'd0, s0_ready}, 32'd1);
        chk("rw_rr0_s1", {31'd0, s1_ready}, 32'd0);
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        chk("rw_dv_after", {31'd0, data_valid}, 32'd1);
        chk("rw_grant_after", {31'd0, grant_src}, 32'd0);
        wait_idle("rw_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
